mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Arbitrates a single sram-like memory port between the IF-stage fetch requester and the EXE-stage data requester of the five-stage LoongArch pipeline. Requests are issued with a req/addr_ok handshake. Completions arrive in order on data_ok. The block keeps an in-order queue of requester IDs so that each completion is routed back to the requester that issued it. It sits between the stage modules and the memory bridge, so the top level needs only one memory port.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- OUTS_DEPTH, 4, maximum number of outstanding transactions (power of two, ≥2)

Ports (x = inst, data):
- clk  in  1  clock. All state updates on the rising edge.
- resetn  in  1  reset. Asynchronous, active-low.
- x_req  in  1  request valid. Held with its payload until x_addr_ok.
- x_wr  in  1  1 = write, 0 = read
- x_size  in  2  0 = byte, 1 = half, 2 = word
- x_wstrb  in  DATA_W/8  write byte strobes
- x_addr  in  ADDR_W  address
- x_wdata  in  DATA_W  write data
- x_addr_ok  out  1  request accepted this cycle
- x_data_ok  out  1  completion for this requester this cycle
- x_rdata  out  DATA_W  read data, valid with x_data_ok
- mem_req  out  1  downstream request valid
- mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  out  1/2/DATA_W/8/ADDR_W/DATA_W  payload muxed from the selected requester
- mem_addr_ok  in  1  downstream accepted the request
- mem_data_ok  in  1  downstream completion, strictly in issue order
- mem_rdata  in  DATA_W  downstream read data

## Operation
- Selection:
  - If the lock is set, select the locked ID.
  - Otherwise, if data_req is high, select DATA. Data has priority because it belongs to an older instruction.
  - Otherwise, if inst_req is high, select INST.
- mem_req = req of the selected requester & ~queue_full & resetn.
- Payload signals are a combinational mux of the selected requester's fields.
- Acceptance: sel_addr_ok = mem_req & mem_addr_ok. The addr_ok of the other requester is 0.
- Lock: set when mem_req & ~mem_addr_ok, which holds the presented requester until it is accepted. The lock is cleared on acceptance. The mem payload therefore never changes mid-handshake.
- ID queue: OUTS_DEPTH entries of 1 bit. Push the selected ID on acceptance. Pop on mem_data_ok.
  - The head ID drives data_ok: inst_data_ok = mem_data_ok & head==INST, and likewise for data.
  - mem_rdata is broadcast to both x_rdata.
- Writes also complete through data_ok, matching sram-like semantics.
- Full: when count == OUTS_DEPTH, mem_req = 0, even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-full queue: count is unchanged and both pointers advance.
- mem_data_ok with an empty queue is a protocol error. It is ignored: no data_ok is raised and count stays 0.
- Pointers wrap modulo OUTS_DEPTH.

## Timing
- Zero added request latency: x_req → mem_req and mem_addr_ok → x_addr_ok are combinational.
- Completion routing is combinational from mem_data_ok. Queue state updates on the following edge.
- Back-to-back issue of one request per cycle is supported while the queue is not full.
- Reset values:
  - queue empty, count 0, lock 0, last-grant = INST
  - all outputs 0 while resetn is low (mem_req is gated; data_ok needs a non-empty queue)
- Reset mid-operation discards all outstanding IDs. Completions that arrive after release hit an empty queue and are dropped.

## Configuration
- MEM_ARB_RR_EN defined: when unlocked and both requests are high, grant the ID opposite to last-grant. last-grant is updated on every acceptance.
- Without MEM_ARB_RR_EN: fixed DATA-over-INST priority. last-grant is not implemented.

## Structure
- Shared package mem_arb_pkg holds:
  - ID encoding: ID_INST = 1'b0, ID_DATA = 1'b1
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD
- One sub-module, mem_arb_idq: a parameterised 1-bit in-order FIFO providing push, pop, head, full and empty.

## Test plan
- Fetch alone: inst_req with addr 0x1c000000, mem_addr_ok = 1 → inst_addr_ok the same cycle. A later mem_data_ok with rdata 0x02800c0c → inst_data_ok = 1, inst_rdata = 0x02800c0c, data_data_ok = 0.
- Contention (default build): inst_req and data_req both high in the same cycle → DATA is accepted first and INST in the next cycle. Completions return DATA then INST.
- Stall/lock: data_req is presented with mem_addr_ok = 0 for 3 cycles while inst_req is also high → mem_addr stays the data address for all 3 cycles. DATA is accepted on cycle 4 before INST.
- Full: accept 4 requests with no completions → mem_req = 0 on the 5th request. One mem_data_ok → issue resumes on the next cycle.
- Reset: with 2 transactions outstanding, pulse resetn low → queue empty. A stray mem_data_ok afterwards → neither data_ok is raised.
- MEM_ARB_RR_EN build: both requesters continuously requesting → grants alternate D, I, D, I.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: requester IDs and access sizes.
package mem_arb_pkg;

   typedef enum logic {
      ID_INST = 1'b0,
      ID_DATA = 1'b1
   } arb_id_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_arb_idq.sv
// In-order FIFO of 1-bit requester IDs; a completion always belongs to the head entry.
module mem_arb_idq
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    resetn,
   input  logic    push,
   input  arb_id_e push_id,
   input  logic    pop,
   output arb_id_e head,
   output logic    full,
   output logic    empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DEPTH-1:0] ent_q, ent_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW:0]      cnt_q, cnt_d;
   logic             push_ok_s, pop_ok_s;

   // Next-state for storage, pointers and occupancy; pops on an empty queue are dropped.
   always_comb begin
      ent_d     = ent_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      push_ok_s = push & ~full;
      pop_ok_s  = pop & ~empty;
      if (push_ok_s) begin
         ent_d[wr_ptr_q] = push_id;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   cnt_d = cnt_q + (PW+1)'(1);
         2'b01:   cnt_d = cnt_q - (PW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // Queue state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ent_q    <= {DEPTH{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         rd_ptr_q <= {PW{1'b0}};
         cnt_q    <= {(PW+1){1'b0}};
      end else begin
         ent_q    <= ent_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign head  = arb_id_e'(ent_q[rd_ptr_q]);
   assign full  = (cnt_q == (PW+1)'(DEPTH));
   assign empty = (cnt_q == {(PW+1){1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like memory port between the fetch (inst) and data requesters.
// Optional round-robin on contention: define MEM_ARB_RR_EN.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int OUTS_DEPTH = 4
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                inst_req,
   input  logic                inst_wr,
   input  logic [1:0]          inst_size,
   input  logic [DATA_W/8-1:0] inst_wstrb,
   input  logic [ADDR_W-1:0]   inst_addr,
   input  logic [DATA_W-1:0]   inst_wdata,
   output logic                inst_addr_ok,
   output logic                inst_data_ok,
   output logic [DATA_W-1:0]   inst_rdata,
   input  logic                data_req,
   input  logic                data_wr,
   input  logic [1:0]          data_size,
   input  logic [DATA_W/8-1:0] data_wstrb,
   input  logic [ADDR_W-1:0]   data_addr,
   input  logic [DATA_W-1:0]   data_wdata,
   output logic                data_addr_ok,
   output logic                data_data_ok,
   output logic [DATA_W-1:0]   data_rdata,
   output logic                mem_req,
   output logic                mem_wr,
   output logic [1:0]          mem_size,
   output logic [DATA_W/8-1:0] mem_wstrb,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_addr_ok,
   input  logic                mem_data_ok,
   input  logic [DATA_W-1:0]   mem_rdata
);

   arb_id_e sel_id_s;
   logic    sel_req_s;
   logic    accept_s;
   logic    lock_q, lock_d;
   arb_id_e lock_id_q, lock_id_d;
   arb_id_e head_s;
   logic    full_s, empty_s;
`ifdef MEM_ARB_RR_EN
   arb_id_e last_q, last_d;
`endif

   // Requester selection: a stalled request keeps the port until it is accepted.
   always_comb begin
      sel_id_s = ID_INST;
      if (lock_q) begin
         sel_id_s = lock_id_q;
      end else if (data_req && inst_req) begin
`ifdef MEM_ARB_RR_EN
         sel_id_s = (last_q == ID_DATA) ? ID_INST : ID_DATA;
`else
         sel_id_s = ID_DATA;
`endif
      end else if (data_req) begin
         sel_id_s = ID_DATA;
      end else begin
         sel_id_s = ID_INST;
      end
   end

   // Downstream request, payload mux and handshake/lock bookkeeping.
   always_comb begin
      sel_req_s = (sel_id_s == ID_DATA) ? data_req : inst_req;
      mem_req   = sel_req_s & ~full_s & resetn;
      accept_s  = mem_req & mem_addr_ok;
      mem_wr    = 1'b0;
      mem_size  = 2'd0;
      mem_wstrb = {(DATA_W/8){1'b0}};
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      if (!resetn) begin
         mem_wr = 1'b0;
      end else if (sel_id_s == ID_DATA) begin
         mem_wr    = data_wr;
         mem_size  = data_size;
         mem_wstrb = data_wstrb;
         mem_addr  = data_addr;
         mem_wdata = data_wdata;
      end else begin
         mem_wr    = inst_wr;
         mem_size  = inst_size;
         mem_wstrb = inst_wstrb;
         mem_addr  = inst_addr;
         mem_wdata = inst_wdata;
      end
      inst_addr_ok = accept_s & (sel_id_s == ID_INST);
      data_addr_ok = accept_s & (sel_id_s == ID_DATA);
      lock_d       = lock_q;
      lock_id_d    = lock_id_q;
      if (mem_req && !mem_addr_ok) begin
         lock_d    = 1'b1;
         lock_id_d = sel_id_s;
      end else if (accept_s) begin
         lock_d    = 1'b0;
         lock_id_d = lock_id_q;
      end else begin
         lock_d    = lock_q;
         lock_id_d = lock_id_q;
      end
   end

`ifdef MEM_ARB_RR_EN
   // Remember the most recent grant for round-robin tie breaking.
   always_comb begin
      if (accept_s) begin
         last_d = sel_id_s;
      end else begin
         last_d = last_q;
      end
   end

   // Last-grant register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_q <= ID_INST;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   // Handshake lock register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_q    <= 1'b0;
         lock_id_q <= ID_INST;
      end else begin
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
      end
   end

   mem_arb_idq #(
      .DEPTH (OUTS_DEPTH)
   ) u_idq (
      .clk     (clk),
      .resetn  (resetn),
      .push    (accept_s),
      .push_id (sel_id_s),
      .pop     (mem_data_ok),
      .head    (head_s),
      .full    (full_s),
      .empty   (empty_s)
   );

   // Completions go to the requester at the head; a stray completion on an empty queue is dropped.
   assign inst_data_ok = mem_data_ok & ~empty_s & (head_s == ID_INST);
   assign data_data_ok = mem_data_ok & ~empty_s & (head_s == ID_DATA);
   assign inst_rdata   = resetn ? mem_rdata : {DATA_W{1'b0}};
   assign data_rdata   = resetn ? mem_rdata : {DATA_W{1'b0}};

endmodule
